// File: rtl/alu_iter.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops resolve in one cycle after accept; mul/divu/remu iterate one bit per cycle.
module alu_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             dbz
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, EXEC, BUSY, DONE} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             op_q;
  logic [WIDTH-1:0]       a_q, b_q;
  logic [2*WIDTH-1:0]     acc_q, acc_nxt;
  logic [SW-1:0]          cnt_q;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH:0]          sum_w, dif_w, mul_sum, div_sh, div_dif;
  logic [WIDTH-1:0]        res_s, res_l;
  logic                    c_s, v_s, dbz_s, long_s, c_l;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  assign a_s   = a_q;
  assign b_s   = b_q;
  assign sum_w = {1'b0, a_q} + {1'b0, b_q};
  assign dif_w = {1'b0, a_q} - {1'b0, b_q};

  // Single-cycle result path, evaluated in EXEC from the latched operands
  always_comb begin
    res_s  = '0;
    c_s    = 1'b0;
    v_s    = 1'b0;
    dbz_s  = 1'b0;
    long_s = 1'b0;
    case (op_q)
      4'd0: begin
        res_s = sum_w[WIDTH-1:0];
        c_s   = sum_w[WIDTH];
        v_s   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'd1: begin
        res_s = dif_w[WIDTH-1:0];
        c_s   = dif_w[WIDTH];
        v_s   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'd2:  res_s = a_q & b_q;
      4'd3:  res_s = a_q | b_q;
      4'd4:  res_s = WIDTH'(a_q == b_q);
      4'd5:  res_s = WIDTH'(a_q <= b_q);
      4'd6:  res_s = a_q ^ b_q;
      4'd7:  res_s = WIDTH'(a_s < b_s);
      4'd8:  res_s = a_q << b_q[SW-1:0];
      4'd9:  res_s = a_q >> b_q[SW-1:0];
      4'd10: long_s = 1'b1;
      4'd11, 4'd12: begin
        if (b_q == '0) begin
          dbz_s = 1'b1;
          res_s = (op_q == 4'd11) ? '1 : a_q;
        end else begin
          long_s = 1'b1;
        end
      end
      default: res_s = '0;
    endcase
  end

  // Iteration step: shift-add multiply on {hi, multiplier}, restoring divide on {rem, quotient}
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_dif = div_sh - {1'b0, b_q};
    if (op_q == 4'd10)
      acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    else if (!div_dif[WIDTH])
      acc_nxt = {div_dif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      acc_nxt = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    res_l = (op_q == 4'd12) ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
    c_l   = (op_q == 4'd10) && (acc_nxt[2*WIDTH-1:WIDTH] != '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = EXEC;
      EXEC: state_nxt = long_s ? BUSY : DONE;
      BUSY: if (cnt_q == SW'(WIDTH - 1)) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and visible result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt_q     <= '0;
      ALUResult <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        EXEC: begin
          cnt_q <= '0;
          if (!long_s) begin
            ALUResult <= res_s;
            zero      <= (res_s == '0);
            carry     <= c_s;
            overflow  <= v_s;
            dbz       <= dbz_s;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + SW'(1);
          if (cnt_q == SW'(WIDTH - 1)) begin
            ALUResult <= res_l;
            zero      <= (res_l == '0);
            carry     <= c_l;
            overflow  <= 1'b0;
            dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      op_q <= ALUOp;
      a_q  <= A;
      b_q  <= B;
    end
    if (state == EXEC)
      acc_q <= (op_q == 4'd10) ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{1'b0}}, a_q};
    else if (state == BUSY)
      acc_q <= acc_nxt;
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed and randomized bench for alu_iter (WIDTH=16) against an arithmetic reference model.
module tb_alu_iter;

  localparam int W = 16;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]    ALUOp;
  logic [W-1:0]  A, B, ALUResult;
  logic          zero, carry, overflow, dbz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flags;   // {zero, carry, overflow, dbz}
    int          lat;
  } exp_t;

  alu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .zero(zero), .carry(carry), .overflow(overflow), .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    int     ua, ub, sa, sb, r;
    longint p;
    logic   c, v, d;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    r = 0; c = 0; v = 0; d = 0; e.lat = 1;
    case (op)
      0:  begin r = ua + ub; c = (r > 65535); v = ((sa + sb) > 32767) || ((sa + sb) < -32768); end
      1:  begin r = ua - ub; c = (ua < ub);  v = ((sa - sb) > 32767) || ((sa - sb) < -32768); end
      2:  r = ua & ub;
      3:  r = ua | ub;
      4:  r = (ua == ub) ? 1 : 0;
      5:  r = (ua <= ub) ? 1 : 0;
      6:  r = ua ^ ub;
      7:  r = (sa < sb) ? 1 : 0;
      8:  r = (ua << (ub % 16)) & 65535;
      9:  r = ua >> (ub % 16);
      10: begin p = longint'(ua) * longint'(ub); r = int'(p & 65535); c = (p > 65535); e.lat = 17; end
      11: if (ub == 0) begin r = 65535; d = 1; end else begin r = ua / ub; e.lat = 17; end
      12: if (ub == 0) begin r = ua; d = 1; end else begin r = ua % ub; e.lat = 17; end
      default: r = 0;
    endcase
    e.res   = 16'(r & 65535);
    e.flags = {(e.res == 16'h0), c, v, d};
    return e;
  endfunction

  // Issue one op from IDLE, follow it to DONE, optionally hold out_ready low, then hand it off.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input int hold);
    exp_t e;
    int   lat;
    logic ir_ok;
    e = model(op, a, b);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    ALUOp = op; A = a; B = b; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; A = 16'($urandom); B = 16'($urandom); ALUOp = 4'($urandom);
    lat = 0; ir_ok = 1'b1;
    while (!out_valid && lat < 60) begin
      if (in_ready !== 1'b0) ir_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready !== 1'b0) ir_ok = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(e.lat));
    check({tag, "_res"}, 32'(ALUResult), 32'(e.res));
    check({tag, "_flags"}, 32'({zero, carry, overflow, dbz}), 32'(e.flags));
    check({tag, "_busy_ready"}, 32'(ir_ok), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, {11'd0, out_valid, in_ready, zero, carry, overflow, dbz, ALUResult},
            {11'd0, 1'b1, 1'b0, e.flags, e.res});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_release"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [15:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ALUOp = '0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {25'd0, in_ready, out_valid, zero, carry, overflow, dbz, 1'b0},
          32'd0);
    check("reset_result", 32'(ALUResult), 32'd0);
    rst = 1'b0;
    #1;
    check("release_ready", 32'(in_ready), 32'd1);

    run_op("add_wrap", 4'd0,  16'hFFFF, 16'h0001, 0);
    run_op("sub_ovf",  4'd1,  16'h8000, 16'h0001, 0);
    run_op("slt",      4'd7,  16'hFFFF, 16'h0001, 0);
    run_op("ule",      4'd5,  16'hFFFF, 16'h0001, 0);
    run_op("mul300",   4'd10, 16'd300,  16'd300,  0);
    run_op("divu",     4'd11, 16'd100,  16'd7,    0);
    run_op("remu",     4'd12, 16'd100,  16'd7,    0);
    run_op("divu_dbz", 4'd11, 16'd5,    16'd0,    0);
    run_op("remu_dbz", 4'd12, 16'd5,    16'd0,    0);
    run_op("xor_bp",   4'd6,  16'h0F0F, 16'h00FF, 5);
    run_op("illegal",  4'd13, 16'h1234, 16'h5678, 0);
    run_op("sll",      4'd8,  16'h8001, 16'd17,   0);
    run_op("sub_pre",  4'd1,  16'h8000, 16'h0001, 0);

    // Abort a multiply partway through its iterations
    ALUOp = 4'd10; A = 16'd300; B = 16'd300; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_mul_busy", 32'({out_valid, in_ready}), 32'b00);
    rst = 1'b1;
    #1;
    check("abort_ctl", 32'({in_ready, out_valid, zero, carry, overflow, dbz}), 32'd0);
    check("abort_result", 32'(ALUResult), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_hold", 32'({in_ready, out_valid}), 32'd0);
    rst = 1'b0;
    #1;
    run_op("post_rst_add", 4'd0, 16'd2, 16'd3, 0);

    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      if (rop == 4'd10 && rb == 16'd0) rb = 16'd1;
      run_op($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb, (n % 7 == 3) ? 2 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
